// File: rtl/io_frame_pkg.sv
// Shared constants, state type and snapshot packing for the IO frame scheduler.
// Frame lengths for both builds live here; the top picks one with IO_FRAME_CHECKSUM_EN.
package io_frame_pkg;

   localparam logic [7:0] HDR_STATUS = 8'hA5;
   localparam logic [7:0] HDR_ACK    = 8'h5A;

   localparam int STATUS_LEN_PLAIN = 8;
   localparam int STATUS_LEN_CSUM  = 9;
   localparam int ACK_LEN_PLAIN    = 2;
   localparam int ACK_LEN_CSUM     = 3;

   localparam int SNAP_W   = 56;
   localparam int OFS_LEDS = 0;
   localparam int OFS_7S0  = 10;
   localparam int OFS_7S1  = 17;
   localparam int OFS_7S2  = 24;
   localparam int OFS_7S3  = 31;
   localparam int OFS_7S4  = 38;
   localparam int OFS_7S5  = 45;
   localparam int OFS_PAD  = 52;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } frame_state_t;

   function automatic logic [SNAP_W-1:0] pack_snapshot(
      input logic [9:0] leds,
      input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
      input logic [6:0] s3, input logic [6:0] s4, input logic [6:0] s5);
      logic [SNAP_W-1:0] v;
      v = '0;
      v[OFS_LEDS +: 10] = leds;
      v[OFS_7S0  +: 7]  = s0;
      v[OFS_7S1  +: 7]  = s1;
      v[OFS_7S2  +: 7]  = s2;
      v[OFS_7S3  +: 7]  = s3;
      v[OFS_7S4  +: 7]  = s4;
      v[OFS_7S5  +: 7]  = s5;
      return v;
   endfunction

endpackage

// File: rtl/io_rate_tick.sv
// Free-running divider: one-cycle o_TICK every clock/rate cycles, first tick
// exactly clock/rate cycles after reset release.
module io_rate_tick #(
   parameter int clock = 50000000,
   parameter int rate  = 20
) (
   input  logic i_CLK,
   input  logic i_RST,
   output logic o_TICK
);

   localparam int RATE_SAFE = (rate < 1) ? 1 : rate;
   localparam int DIV_RAW   = clock / RATE_SAFE;
   localparam int DIV       = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int CW        = ($clog2(DIV) < 1) ? 1 : $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          r_tick;

   always_ff @(posedge i_CLK) begin
      if (!i_RST) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else if (r_cnt == LAST) begin
         r_cnt  <= '0;
         r_tick <= 1'b1;
      end else begin
         r_cnt  <= r_cnt + 1'b1;
         r_tick <= 1'b0;
      end
   end

   assign o_TICK = r_tick;

endmodule

// File: rtl/io_frame_scheduler.sv
// Schedules periodic status frames and on-demand ack frames onto a byte stream.
// Define IO_FRAME_CHECKSUM_EN to append an XOR checksum byte to every frame.
module io_frame_scheduler
   import io_frame_pkg::*;
#(
   parameter int clock = 50000000,
   parameter int rate  = 20
) (
   input  logic       i_CLK,
   input  logic       i_RST,
   input  logic [9:0] i_LEDS,
   input  logic [6:0] i_7S0,
   input  logic [6:0] i_7S1,
   input  logic [6:0] i_7S2,
   input  logic [6:0] i_7S3,
   input  logic [6:0] i_7S4,
   input  logic [6:0] i_7S5,
   input  logic       i_ACK_REQ,
   input  logic [7:0] i_ACK_CODE,
   output logic [7:0] o_TX_DATA,
   output logic       o_TX_VALID,
   input  logic       i_TX_READY,
   output logic       o_BUSY,
   output logic       o_FRAME_DONE,
   output logic       o_ACK_OVF,
   output logic [1:0] o_STATE
);

`ifdef IO_FRAME_CHECKSUM_EN
   localparam int STAT_LEN = STATUS_LEN_CSUM;
   localparam int ACK_LEN  = ACK_LEN_CSUM;
`else
   localparam int STAT_LEN = STATUS_LEN_PLAIN;
   localparam int ACK_LEN  = ACK_LEN_PLAIN;
`endif
   localparam logic [3:0] STAT_LAST = 4'(STAT_LEN - 1);
   localparam logic [3:0] ACK_LAST  = 4'(ACK_LEN - 1);

   frame_state_t      r_state;
   frame_state_t      w_state_nxt;
   logic              r_stat_pend;
   logic              r_ack_pend;
   logic              r_ack_ovf;
   logic              r_is_ack;
   logic [7:0]        r_ack_code;
   logic [SNAP_W-1:0] r_snap;
   logic [3:0]        r_idx;

   logic              w_tick;
   logic              w_sel;
   logic              w_sel_ack;
   logic              w_sel_stat;
   logic              w_ack_blocked;
   logic              w_xfer;
   logic              w_last;
   logic [7:0]        w_byte;
   logic [SNAP_W-1:0] w_snap_in;

   io_rate_tick #(.clock(clock), .rate(rate)) u_tick (
      .i_CLK (i_CLK),
      .i_RST (i_RST),
      .o_TICK(w_tick)
   );

   assign w_snap_in = pack_snapshot(i_LEDS, i_7S0, i_7S1, i_7S2, i_7S3, i_7S4, i_7S5);

   assign w_sel         = (r_state == ST_IDLE) && (r_stat_pend || r_ack_pend);
   assign w_sel_ack     = w_sel && r_ack_pend;
   assign w_sel_stat    = w_sel && !r_ack_pend;
   // A request only collides when the pending ack is not being consumed this edge.
   assign w_ack_blocked = r_ack_pend && !w_sel_ack;
   // Handshake: a byte moves on every edge where o_TX_VALID and i_TX_READY are both
   // high; until then o_TX_VALID stays high and o_TX_DATA holds its value.
   assign w_xfer        = (r_state == ST_SEND) && i_TX_READY;
   assign w_last        = r_is_ack ? (r_idx == ACK_LAST) : (r_idx == STAT_LAST);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_sel) w_state_nxt = ST_SEND;
         ST_SEND: if (w_xfer && w_last) w_state_nxt = ST_DONE;
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

`ifdef IO_FRAME_CHECKSUM_EN
   logic [7:0] r_csum;
   logic [7:0] w_csum_in;

   always_comb begin
      w_csum_in = 8'h00;
      for (int k = 0; k < 7; k++) w_csum_in = w_csum_in ^ w_snap_in[8*k +: 8];
   end

   always_ff @(posedge i_CLK) begin
      if (!i_RST) r_csum <= 8'h00;
      else if (w_sel_stat) r_csum <= w_csum_in;
   end
`endif

   always_comb begin
      w_byte = 8'h00;
      if (r_idx == 4'd0) begin
         w_byte = r_is_ack ? HDR_ACK : HDR_STATUS;
      end else if (r_is_ack) begin
         if (r_idx == 4'd1) w_byte = r_snap[7:0];
`ifdef IO_FRAME_CHECKSUM_EN
         if (r_idx == 4'd2) w_byte = ~r_snap[7:0];
`endif
      end else begin
         for (int k = 0; k < 7; k++) if (r_idx == 4'(k + 1)) w_byte = r_snap[8*k +: 8];
`ifdef IO_FRAME_CHECKSUM_EN
         if (r_idx == 4'd8) w_byte = r_csum;
`endif
      end
   end

   always_ff @(posedge i_CLK) begin
      if (!i_RST) begin
         r_state     <= ST_IDLE;
         r_stat_pend <= 1'b0;
         r_ack_pend  <= 1'b0;
         r_ack_ovf   <= 1'b0;
         r_is_ack    <= 1'b0;
         r_ack_code  <= 8'h00;
         r_snap      <= '0;
         r_idx       <= 4'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_ack_ovf   <= i_ACK_REQ && w_ack_blocked;
         r_stat_pend <= (r_stat_pend && !w_sel_stat) || w_tick;
         if (i_ACK_REQ && !w_ack_blocked) begin
            r_ack_pend <= 1'b1;
            r_ack_code <= i_ACK_CODE;
         end else if (w_sel_ack) begin
            r_ack_pend <= 1'b0;
         end
         // Ack frames reuse the payload register so a late request cannot alter them.
         if (w_sel) begin
            r_idx    <= 4'd0;
            r_is_ack <= r_ack_pend;
            r_snap   <= r_ack_pend ? {48'h0, r_ack_code} : w_snap_in;
         end else if (w_xfer && !w_last) begin
            r_idx <= r_idx + 4'd1;
         end
      end
   end

   assign o_TX_VALID   = i_RST && (r_state == ST_SEND);
   assign o_TX_DATA    = o_TX_VALID ? w_byte : 8'h00;
   assign o_BUSY       = i_RST && (r_state != ST_IDLE);
   assign o_FRAME_DONE = i_RST && (r_state == ST_DONE);
   assign o_ACK_OVF    = i_RST && r_ack_ovf;
   assign o_STATE      = r_state;

endmodule

// File: tb/tb_io_frame_scheduler.sv
// Self-checking bench for io_frame_scheduler (clock=1000, rate=10: tick every 100 cycles).
// Expected bytes come from an independent snapshot model pushed into exp_q.
module tb_io_frame_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] leds;
   logic [6:0] s0, s1, s2, s3, s4, s5;
   logic       ack_req;
   logic [7:0] ack_code;
   logic       tx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       busy;
   logic       frame_done;
   logic       ack_ovf;
   logic [1:0] dbg_state;

   int         n_cmp = 0;
   int         n_err = 0;
   int         done_cnt = 0;
   int         ovf_cnt = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   io_frame_scheduler #(.clock(1000), .rate(10)) dut (
      .i_CLK       (clk),
      .i_RST       (rst_n),
      .i_LEDS      (leds),
      .i_7S0       (s0),
      .i_7S1       (s1),
      .i_7S2       (s2),
      .i_7S3       (s3),
      .i_7S4       (s4),
      .i_7S5       (s5),
      .i_ACK_REQ   (ack_req),
      .i_ACK_CODE  (ack_code),
      .o_TX_DATA   (tx_data),
      .o_TX_VALID  (tx_valid),
      .i_TX_READY  (tx_ready),
      .o_BUSY      (busy),
      .o_FRAME_DONE(frame_done),
      .o_ACK_OVF   (ack_ovf),
      .o_STATE     (dbg_state)
   );

   always @(negedge clk) begin
      if (frame_done) done_cnt++;
      if (ack_ovf) ovf_cnt++;
   end

   // ---------------- driver tasks ----------------
   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      wait_edges(3);
      rst_n = 1'b1;
   endtask

   task automatic set_inputs(input logic [9:0] l, input logic [6:0] h);
      leds = l; s0 = h; s1 = h; s2 = h; s3 = h; s4 = h; s5 = h;
   endtask

   task automatic pulse_ack(input logic [7:0] code);
      ack_req = 1'b1; ack_code = code;
      wait_edges(1);
      ack_req = 1'b0;
   endtask

   // Returns the next transferred byte; ok=0 if none arrives within the budget.
   task automatic wait_xfer(output logic [7:0] b, output bit ok);
      ok = 1'b0; b = 8'h00;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         if (tx_valid && tx_ready) begin b = tx_data; ok = 1'b1; end
         @(posedge clk); #1;
      end
   endtask

   // ---------------- scoreboard model ----------------
   task automatic push_status();
      logic [55:0] snap;
      snap = {4'h0, s5, s4, s3, s2, s1, s0, leds};
      exp_q.push_back(8'hA5);
      for (int k = 0; k < 7; k++) exp_q.push_back(snap[8*k +: 8]);
`ifdef IO_FRAME_CHECKSUM_EN
      begin
         logic [7:0] x;
         x = 8'h00;
         for (int k = 0; k < 7; k++) x = x ^ snap[8*k +: 8];
         exp_q.push_back(x);
      end
`endif
   endtask

   task automatic push_ack(input logic [7:0] code);
      exp_q.push_back(8'h5A);
      exp_q.push_back(code);
`ifdef IO_FRAME_CHECKSUM_EN
      exp_q.push_back(code ^ 8'hFF);
`endif
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      wait_edges(2);
      n_cmp++;
      if (tx_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || ack_ovf !== 1'b0 ||
          tx_data !== 8'h00 || dbg_state !== 2'(io_frame_pkg::ST_IDLE)) begin
         n_err++;
         $display("FAIL reset_outputs: valid=%b busy=%b done=%b ovf=%b data=%h state=%0d, required all zero/IDLE",
                  tx_valid, busy, frame_done, ack_ovf, tx_data, dbg_state);
      end
      rst_n = 1'b1;
      wait_edges(101);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++; $display("FAIL first_tick_early: busy=%b at cycle 101, required 0", busy);
      end
      wait_edges(1);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++; $display("FAIL first_tick_late: busy=%b at cycle 102, required 1", busy);
      end
   endtask

   task automatic test_basic();
      logic [7:0] b;
      bit ok;
      int d0;
      set_inputs(10'h3FF, 7'h7F);
      tx_ready = 1'b1;
      apply_reset();
      d0 = done_cnt;
      push_status();
      while (exp_q.size() > 0) begin
         logic [7:0] e;
         wait_xfer(b, ok);
         e = exp_q.pop_front();
         n_cmp++;
         if (!ok) begin
            n_err++; $display("FAIL basic_timeout: no byte, required %h", e); exp_q.delete();
         end else if (b !== e) begin
            n_err++; $display("FAIL basic_byte: got %h required %h", b, e);
         end
      end
      n_cmp++;
      if (frame_done !== 1'b1 || tx_valid !== 1'b0 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL basic_done_cycle: done=%b valid=%b busy=%b, required 1 0 1", frame_done, tx_valid, busy);
      end
      wait_edges(1);
      n_cmp++;
      if (busy !== 1'b0 || frame_done !== 1'b0) begin
         n_err++; $display("FAIL basic_idle_after_done: busy=%b done=%b, required 0 0", busy, frame_done);
      end
      wait_edges(3);
      n_cmp++;
      if (done_cnt - d0 != 1) begin
         n_err++; $display("FAIL basic_done_pulses: got %0d required 1", done_cnt - d0);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] held;
      bit held_v;
      int cyc;
      set_inputs(10'($urandom_range(0, 1023)), 7'($urandom_range(0, 127)));
      s3 = 7'($urandom_range(0, 127));
      s5 = 7'($urandom_range(0, 127));
      tx_ready = 1'b0;
      apply_reset();
      push_status();
      held_v = 1'b0; held = 8'h00; cyc = 0;
      while (exp_q.size() > 0 && cyc < 600) begin
         bit took;
         took = 1'b0;
         tx_ready = (cyc % 3 == 2);
         @(negedge clk);
         if (held_v) begin
            n_cmp++;
            if (tx_valid !== 1'b1 || tx_data !== held) begin
               n_err++;
               $display("FAIL bp_stable: valid=%b data=%h, required 1 %h", tx_valid, tx_data, held);
            end
         end
         if (tx_valid) begin
            if (tx_ready) begin
               logic [7:0] e;
               e = exp_q.pop_front();
               n_cmp++;
               if (tx_data !== e) begin
                  n_err++; $display("FAIL bp_byte: got %h required %h", tx_data, e);
               end
               held_v = 1'b0; took = 1'b1;
            end else begin
               held = tx_data; held_v = 1'b1;
            end
         end
         @(posedge clk); #1;
         cyc++;
         if (took) begin
            leds = 10'($urandom_range(0, 1023));
            s0 = 7'($urandom_range(0, 127));
            s4 = 7'($urandom_range(0, 127));
         end
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++; $display("FAIL bp_timeout: %0d bytes left, required 0", exp_q.size()); exp_q.delete();
      end
   endtask

   task automatic test_ack_with_tick();
      logic [7:0] b;
      bit ok;
      set_inputs(10'h155, 7'h2A);
      tx_ready = 1'b1;
      apply_reset();
      push_ack(8'h42);
      push_status();
      wait_edges(100);
      pulse_ack(8'h42);
      while (exp_q.size() > 0) begin
         logic [7:0] e;
         wait_xfer(b, ok);
         e = exp_q.pop_front();
         n_cmp++;
         if (!ok) begin
            n_err++; $display("FAIL ack_tick_timeout: no byte, required %h", e); exp_q.delete();
         end else if (b !== e) begin
            n_err++; $display("FAIL ack_tick_byte: got %h required %h", b, e);
         end
      end
   endtask

   task automatic test_ack_ovf();
      logic [7:0] b;
      bit ok;
      int o0;
      set_inputs(10'h2C3, 7'h15);
      tx_ready = 1'b0;
      apply_reset();
      wait_edges(105);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++; $display("FAIL ovf_busy: busy=%b required 1", busy);
      end
      o0 = ovf_cnt;
      pulse_ack(8'h11);
      wait_edges(2);
      pulse_ack(8'h22);
      wait_edges(3);
      n_cmp++;
      if (ovf_cnt - o0 != 1) begin
         n_err++; $display("FAIL ovf_pulses: got %0d required 1", ovf_cnt - o0);
      end
      n_cmp++;
      if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
         n_err++; $display("FAIL ovf_frame_held: valid=%b data=%h, required 1 a5", tx_valid, tx_data);
      end
      tx_ready = 1'b1;
      push_status();
      push_ack(8'h11);
      exp_q.push_back(8'hA5);
      while (exp_q.size() > 0) begin
         logic [7:0] e;
         wait_xfer(b, ok);
         e = exp_q.pop_front();
         n_cmp++;
         if (!ok) begin
            n_err++; $display("FAIL ovf_timeout: no byte, required %h", e); exp_q.delete();
         end else if (b !== e) begin
            n_err++; $display("FAIL ovf_byte: got %h required %h", b, e);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] b;
      bit ok;
      set_inputs(10'h0F0, 7'h33);
      tx_ready = 1'b1;
      apply_reset();
      push_status();
      for (int k = 0; k < 3; k++) begin
         logic [7:0] e;
         wait_xfer(b, ok);
         e = exp_q.pop_front();
         n_cmp++;
         if (!ok || b !== e) begin
            n_err++; $display("FAIL rst_mid_prefix: got %h ok=%b required %h", b, ok, e);
         end
      end
      exp_q.delete();
      rst_n = 1'b0;
      wait_edges(1);
      n_cmp++;
      if (tx_valid !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00) begin
         n_err++;
         $display("FAIL rst_mid_abort: valid=%b busy=%b data=%h, required 0 0 00", tx_valid, busy, tx_data);
      end
      wait_edges(1);
      rst_n = 1'b1;
      wait_edges(50);
      n_cmp++;
      if (busy !== 1'b0 || tx_valid !== 1'b0) begin
         n_err++; $display("FAIL rst_mid_resume_early: busy=%b valid=%b, required 0 0", busy, tx_valid);
      end
      push_status();
      while (exp_q.size() > 0) begin
         logic [7:0] e;
         wait_xfer(b, ok);
         e = exp_q.pop_front();
         n_cmp++;
         if (!ok) begin
            n_err++; $display("FAIL rst_mid_timeout: no byte, required %h", e); exp_q.delete();
         end else if (b !== e) begin
            n_err++; $display("FAIL rst_mid_byte: got %h required %h", b, e);
         end
      end
   endtask

   task automatic test_single_led();
      logic [7:0] b;
      bit ok;
      set_inputs(10'h001, 7'h00);
      tx_ready = 1'b1;
      apply_reset();
      push_status();
      while (exp_q.size() > 0) begin
         logic [7:0] e;
         wait_xfer(b, ok);
         e = exp_q.pop_front();
         n_cmp++;
         if (!ok) begin
            n_err++; $display("FAIL led_timeout: no byte, required %h", e); exp_q.delete();
         end else if (b !== e) begin
            n_err++; $display("FAIL led_byte: got %h required %h", b, e);
         end
      end
      n_cmp++;
      if (frame_done !== 1'b1) begin
         n_err++; $display("FAIL led_frame_len: done=%b after last byte, required 1", frame_done);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      ack_req = 1'b0;
      ack_code = 8'h00;
      tx_ready = 1'b0;
      set_inputs(10'h000, 7'h00);
      test_reset();
      test_basic();
      test_backpressure();
      test_ack_with_tick();
      test_ack_ovf();
      test_reset_mid_frame();
      test_single_led();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/io_frame_scheduler.md
IO_FRAME_SCHEDULER -- requirements
Module: io_frame_scheduler

Interface
REQ-001 The block SHALL have parameter clock, default 50000000, meaning i_CLK frequency in Hz.
REQ-002 The block SHALL have parameter rate, default 20, meaning status frames per second.
REQ-003 The block SHALL have port i_CLK  input  1  the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port i_RST  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have ports i_LEDS  input  10 and i_7S5..i_7S0  input  7 each; these carry the board outputs to report.
REQ-006 The block SHALL have ports i_ACK_REQ  input  1 (one-cycle ack request) and i_ACK_CODE  input  8 (ack code, sampled with the request).
REQ-007 The block SHALL have ports o_TX_DATA  output  8 and o_TX_VALID  output  1 (byte offer to the UART transmitter), plus i_TX_READY  input  1 (transmitter accepts).
REQ-008 The block SHALL have ports o_BUSY  output  1 (frame in progress), o_FRAME_DONE  output  1 (one-cycle pulse after the last byte) and o_ACK_OVF  output  1 (one-cycle pulse when an ack is dropped).

Function
REQ-009 A tick SHALL occur every clock/rate cycles, with integer division; each tick SHALL set a status-pending flag, and a tick arriving while the flag is already set SHALL coalesce with it.
REQ-010 An i_ACK_REQ pulse SHALL set an ack-pending flag and latch i_ACK_CODE.
REQ-011 If ack-pending is already set when a new i_ACK_REQ arrives, the new request SHALL be dropped, the latched code SHALL be kept, and o_ACK_OVF SHALL pulse.
REQ-012 The FSM states SHALL be IDLE, SEND and DONE.
REQ-013 In IDLE with any flag pending, the FSM SHALL move to SEND on the next edge; ack SHALL have priority over status.
REQ-014 A flag SHALL clear on the same edge its frame is selected; a request arriving that same edge SHALL re-set the flag.
REQ-015 A status frame SHALL be the header 0xA5 followed by payload bytes P0..P6 of a 56-bit snapshot, least-significant byte first.
REQ-016 The snapshot bit layout SHALL be [9:0]=i_LEDS, [16:10]=i_7S0, [23:17]=i_7S1, [30:24]=i_7S2, [37:31]=i_7S3, [44:38]=i_7S4, [51:45]=i_7S5 and [55:52]=0.
REQ-017 The snapshot SHALL be captured on the IDLE->SEND edge and SHALL be held constant for the whole frame.
REQ-018 An ack frame SHALL be the header 0x5A followed by the latched code.
REQ-019 In SEND, o_TX_VALID SHALL be 1, and o_TX_DATA SHALL hold the current byte and stay stable until a cycle in which i_TX_READY=1; that cycle transfers the byte, and the index SHALL advance on the following edge.
REQ-020 o_TX_VALID SHALL never deassert before the transfer of the byte it offers.
REQ-021 After the last byte transfers, the FSM SHALL go to DONE for exactly one cycle: o_FRAME_DONE=1, o_TX_VALID=0, then IDLE.
REQ-022 Back-to-back frames SHALL therefore be separated by at least one DONE cycle and one IDLE cycle.
REQ-023 o_BUSY SHALL be 1 in SEND and DONE, and 0 in IDLE.
REQ-024 Ticks and ack requests arriving during a frame SHALL never abort or alter the frame in progress.

Reset
REQ-025 When i_RST=0 at a clock edge, the block SHALL enter IDLE.
REQ-026 Reset SHALL clear both pending flags, the byte index and the tick counter.
REQ-027 During reset, o_TX_VALID, o_BUSY, o_FRAME_DONE and o_ACK_OVF SHALL be 0, and o_TX_DATA SHALL be 0x00.
REQ-028 A reset during a frame SHALL abandon the frame; no byte SHALL be offered until a new request follows the release of reset.
REQ-029 The first tick after the release of reset SHALL occur clock/rate cycles after release.

Configuration
REQ-030 With macro IO_FRAME_CHECKSUM_EN defined, status frames SHALL append one byte equal to the XOR of P0..P6, giving 9 bytes, and ack frames SHALL append the code XOR 0xFF, giving 3 bytes.
REQ-031 With IO_FRAME_CHECKSUM_EN undefined, status frames SHALL be 8 bytes and ack frames SHALL be 2 bytes, with no checksum logic.

Structure
REQ-032 Package io_frame_pkg SHALL hold the header constants 0xA5 and 0x5A, the status and ack frame lengths (both variants), the FSM state type and the snapshot bit offsets.
REQ-033 The tick generator SHALL be the sub-module io_rate_tick (parameters clock and rate; ports i_CLK, i_RST, o_TICK).

Verification (clock=1000, rate=10, so a tick every 100 cycles)
REQ-034 Scenario: i_TX_READY=1, i_LEDS=0x3FF, all HEX=0x7F -> bytes A5 FF FF FF FF FF FF 0F; o_FRAME_DONE pulses once.
REQ-035 Scenario: i_TX_READY toggles 1-of-3 cycles and the inputs change mid-frame -> o_TX_DATA is stable while unaccepted, and the payload equals the snapshot taken at frame start.
REQ-036 Scenario: i_ACK_REQ with code 0x42 on the same cycle as a tick -> ack frame 5A 42 first, then the status frame.
REQ-037 Scenario: two ack requests (0x11, then 0x22) while a frame is busy -> o_ACK_OVF pulses once, and only 5A 11 is sent.
REQ-038 Scenario: i_RST=0 after the third byte -> o_TX_VALID=0 next cycle; after release the next frame starts from header A5.
REQ-039 Scenario: with IO_FRAME_CHECKSUM_EN, i_LEDS=0x001 and HEX=0 -> the last byte is 0x01; ack 0x42 -> 5A 42 BD.
